rv0_wbu_i: RTL
==============

// Module: rv0_wbu_i
// PURPOSE
// - Integer writeback unit: sink end of the EXU pipeline buffer (rv_sbuf_if.sink).
// - Accepts executed insns, holds them in a one-entry writeback register and writes rd to the integer register file.
// - Retires every accepted insn in order, maintains the 64-bit retired-instruction counter and drives the
//   bypass (forward) port back towards decode.
// PARAMETERS (RV0_CORE_PARAM_LST)
// - XLEN  32  integer datapath width (32 or 64)
// - FLEN  32  FP width; carried for interface compatibility, unused here
// PORTS
// - clk_i          in   1      clock; all flops on rising edge
// - rst_ni         in   1      asynchronous reset, active-low
// - wbu_flush_i    in   1      pipeline flush: drop the held entry, refuse input this cycle
// - exu_sbuf_if    sink -      rv_sbuf_if.sink: insn[31:0], addr, idata1 (result), rdy in, ack out
// - rf_busy_i      in   1      regfile write port busy; stalls the commit
// - rf_we_o        out  1      regfile write enable
// - rf_waddr_o     out  5      regfile write index (rd)
// - rf_wdata_o     out  XLEN   regfile write data
// - retire_o       out  1      one-cycle pulse per retired insn
// - retire_addr_o  out  XLEN   PC of the retiring insn
// - fwd_vld_o      out  1      held entry writes a nonzero rd (bypass valid)
// - fwd_rd_o       out  5      bypass rd
// - fwd_data_o     out  XLEN   bypass data
// - minstret_o     out  64     retired-instruction count
// BEHAVIOUR
// - Reset: wb_vld_q=0, minstret=0; every output 0 (ack=0 while rst_ni low, 1 the cycle after release).
// - Handshake: transfer iff rdy && ack. ack = !wbu_flush_i && (!wb_vld_q || commit), where
//   commit = wb_vld_q && !rf_busy_i. Accept and commit in the same cycle gives full throughput.
// - Latency: insn accepted at cycle N is visible on rf_we_o/retire_o at cycle N+1 earliest.
// - Write-rd decode (opcode = insn[6:0]): LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111,
//   OP-IMM 0010011, OP 0110011, LOAD 0000011, SYSTEM 1110011 with funct3!=0 -> writes rd.
//   BRANCH 1100011, STORE 0100011, MISC-MEM 0001111, ECALL/EBREAK -> no write. Any other opcode -> no write
//   but still retires (exception handling is out of scope).
// - rd==x0: no write, fwd_vld_o=0, insn still retires.
// - rf_we_o  = commit && wr_rd_q && rd_q!=0; retire_o = commit. Both combinational from flops + rf_busy_i.
// - rf_waddr_o/rf_wdata_o/retire_addr_o/fwd_* are driven from the held entry and are stable while
//   wb_vld_q=1 and rf_busy_i=1 (stall holds the entry, no pulse).
// - fwd_vld_o = wb_vld_q && wr_rd_q && rd_q!=0, independent of rf_busy_i.
// - minstret_o += 1 on each commit; wraps 2^64-1 -> 0 silently.
// - Flush: wb_vld_q cleared next edge; a commit in the flush cycle is suppressed (rf_we_o=0, retire_o=0,
//   counter unchanged); ack=0 so nothing is accepted. Flush has priority over rf_busy_i and rdy.
// - Reset mid-stall discards the held entry; no write is emitted after release.
// STRUCTURE
// - rv0_pkg: opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP, OPC_LOAD,
//   OPC_SYSTEM, OPC_BRANCH, OPC_STORE, OPC_MISC_MEM), rd/funct3 field slice constants.
// - Sub-module rv0_wbu_dec (combinational): insn -> {wr_rd, rd}; reusable by the IDU hazard logic.
// - Top: entry register {insn-derived wr_rd/rd, addr, data}, valid flop, 64-bit counter, handshake glue.
// TESTING
// - Reset: hold rst_ni=0 with rdy=1 -> ack=0, rf_we_o=0, minstret_o=0; release -> ack=1 next cycle.
// - Back-to-back: 3 ADDI (rd=x1,x2,x3, data 0x11,0x22,0x33) rdy=1 every cycle -> rf_we_o high 3
//   consecutive cycles, waddr 1,2,3, wdata 0x11,0x22,0x33, minstret_o=3.
// - No-write: SW, BEQ, ADDI x0 -> rf_we_o never high, retire_o 3 pulses, fwd_vld_o=0 throughout.
// - Stall: ADDI x5=0xAB then rf_busy_i=1 for 4 cycles -> ack=0, outputs held, fwd_vld_o=1 fwd_rd_o=5;
//   busy drop -> single rf_we_o pulse, minstret +1.
// - Flush: held LUI x7, assert wbu_flush_i with rf_busy_i=0 -> no write, no retire, ack=0 that cycle,
//   fwd_vld_o=0 next cycle.
// - Wrap: force counter to 0xFFFF_FFFF_FFFF_FFFF, retire one insn -> minstret_o=0.

Source files
------------

// File: rtl/rv0_pkg.sv
// rtl/rv0_pkg.sv - RV0 opcode map and instruction field slices
package rv0_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;
  localparam int F3_MSB  = 14;
  localparam int F3_LSB  = 12;

  typedef struct packed {
    logic       wr_rd;
    logic [4:0] rd;
  } wb_dec_t;

endpackage

// File: rtl/rv_sbuf_if.sv
// rtl/rv_sbuf_if.sv - pipeline buffer link between EXU (source) and WBU (sink)
interface rv_sbuf_if #(
  parameter int XLEN = 32
);
  logic [31:0]     insn;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] idata1;
  logic            rdy;
  logic            ack;

  modport source (output insn, output addr, output idata1, output rdy, input ack);
  modport sink   (input insn, input addr, input idata1, input rdy, output ack);
endinterface

// File: rtl/rv0_wbu_dec.sv
// rtl/rv0_wbu_dec.sv - decodes whether an insn writes rd, and which rd
module rv0_wbu_dec
  import rv0_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic        wr_rd_o,
  output logic [4:0]  rd_o
);

  logic [6:0] opc;
  logic [2:0] funct3;
  logic       unused_insn;

  assign opc         = insn_i[OPC_MSB:OPC_LSB];
  assign funct3      = insn_i[F3_MSB:F3_LSB];
  assign rd_o        = insn_i[RD_MSB:RD_LSB];
  assign unused_insn = ^insn_i[31:15];

  always_comb begin
    wr_rd_o = 1'b0;
    unique case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP_IMM, OPC_OP, OPC_LOAD: wr_rd_o = 1'b1;
      // funct3==0 is ECALL/EBREAK; the CSR ops write rd
      OPC_SYSTEM:                   wr_rd_o = (funct3 != 3'd0);
      default:                      wr_rd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv0_wbu_i.sv
// rtl/rv0_wbu_i.sv - integer writeback: one-entry hold register, regfile write, retire and bypass
module rv0_wbu_i
  import rv0_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wbu_flush_i,
  rv_sbuf_if.sink         exu_sbuf_if,
  input  logic            rf_busy_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            retire_o,
  output logic [XLEN-1:0] retire_addr_o,
  output logic            fwd_vld_o,
  output logic [4:0]      fwd_rd_o,
  output logic [XLEN-1:0] fwd_data_o,
  output logic [63:0]     minstret_o
);

  if (!(XLEN == 32 || XLEN == 64) || !(FLEN == 32 || FLEN == 64)) begin : g_bad_width
    $error("rv0_wbu_i: XLEN/FLEN must be 32 or 64");
  end

  logic            run_q, run_d;
  logic            wb_vld_q, wb_vld_d;
  logic            wr_rd_q, wr_rd_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [63:0]     minstret_q, minstret_d;

  logic            dec_wr_rd;
  logic [4:0]      dec_rd;
  logic            commit;
  logic            commit_ok;
  logic            ack;
  logic            accept;

  rv0_wbu_dec u_dec (
    .insn_i  (exu_sbuf_if.insn),
    .wr_rd_o (dec_wr_rd),
    .rd_o    (dec_rd)
  );

  always_comb begin
    commit    = wb_vld_q && !rf_busy_i;
    commit_ok = commit && !wbu_flush_i;
    // run_q keeps ack low through reset and for the first edge after release
    ack       = run_q && !wbu_flush_i && (!wb_vld_q || commit);
    accept    = exu_sbuf_if.rdy && ack;

    run_d      = 1'b1;
    wb_vld_d   = wb_vld_q;
    wr_rd_d    = wr_rd_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    minstret_d = minstret_q + {63'd0, commit_ok};

    if (wbu_flush_i) begin
      wb_vld_d = 1'b0;
    end else if (accept) begin
      wb_vld_d = 1'b1;
    end else if (commit) begin
      wb_vld_d = 1'b0;
    end

    if (accept) begin
      wr_rd_d = dec_wr_rd;
      rd_d    = dec_rd;
      addr_d  = exu_sbuf_if.addr;
      data_d  = exu_sbuf_if.idata1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      wb_vld_q   <= 1'b0;
      wr_rd_q    <= 1'b0;
      rd_q       <= 5'd0;
      addr_q     <= '0;
      data_q     <= '0;
      minstret_q <= 64'd0;
    end else begin
      run_q      <= run_d;
      wb_vld_q   <= wb_vld_d;
      wr_rd_q    <= wr_rd_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      minstret_q <= minstret_d;
    end
  end

  assign exu_sbuf_if.ack = ack;

  assign rf_we_o       = commit_ok && wr_rd_q && (rd_q != 5'd0);
  assign rf_waddr_o    = rd_q;
  assign rf_wdata_o    = data_q;
  assign retire_o      = commit_ok;
  assign retire_addr_o = addr_q;
  assign fwd_vld_o     = wb_vld_q && wr_rd_q && (rd_q != 5'd0);
  assign fwd_rd_o      = rd_q;
  assign fwd_data_o    = data_q;
  assign minstret_o    = minstret_q;

endmodule
